// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller: opcodes, FSM states,
// instruction classes and the datapath mux select codes.
package cpu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH,
    CLS_LOAD, CLS_STORE, CLS_OP_IMM, CLS_OP, CLS_SYSTEM, CLS_ILLEGAL
  } instr_class_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  localparam logic [2:0] FUNCT3_SHIFT_RIGHT = 3'b101;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_REL   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  localparam logic SRC_B_RS2 = 1'b0;
  localparam logic SRC_B_IMM = 1'b1;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational instruction decoder: opcode class, rd==x0 flag and ALU op.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t cls,
  output logic         rd_is_zero,
  output logic [3:0]   alu_op
);

  logic [2:0] funct3;
  logic       funct7_5;

  assign funct3     = instr[14:12];
  assign funct7_5   = instr[30];
  assign rd_is_zero = (instr[11:7] == 5'd0);

  // Classify by major opcode only
  always_comb begin
    cls = CLS_ILLEGAL;
    case (instr[6:0])
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_OP_IMM: cls = CLS_OP_IMM;
      OPC_OP:     cls = CLS_OP;
      OPC_SYSTEM: cls = CLS_SYSTEM;
      default:    cls = CLS_ILLEGAL;
    endcase
  end

  // ALU op: funct7[5] only matters for OP-IMM on right shifts (SRLI/SRAI)
  always_comb begin
    alu_op = ALU_ADD;
    case (cls)
      CLS_OP:     alu_op = {funct7_5, funct3};
      CLS_OP_IMM: alu_op = {(funct3 == FUNCT3_SHIFT_RIGHT) ? funct7_5 : 1'b0, funct3};
      CLS_BRANCH: alu_op = ALU_SUB;
      default:    alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control FSM.
//   state     | meaning
//   FETCH     | request instruction at pc, load IR on mem_ready
//   DECODE    | classify opcode, trap on SYSTEM / unknown
//   EXECUTE   | drive ALU operands; branches resolve here
//   MEM       | data access at ALU result, held until mem_ready
//   WRITEBACK | register write and pc update
//   HALT      | parked until reset; halted/illegal flags visible
module cpu_control_fsm
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  wb_sel,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic [1:0]  pc_sel,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  state
);

  // Counter holds 0..MEM_TIMEOUT-1; hitting the last value with ready still low traps
  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t       state_q;
  logic [CW-1:0] wait_cnt;
  instr_class_t cls;
  logic         rd_is_zero;
  logic [3:0]   dec_alu_op;
  logic         wait_expired;

  cpu_decoder u_decoder (
    .instr      (instr),
    .cls        (cls),
    .rd_is_zero (rd_is_zero),
    .alu_op     (dec_alu_op)
  );

  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign state        = state_q;

  // State sequencing, memory wait counter and sticky status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_FETCH;
      wait_cnt <= '0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH, ST_MEM: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            if (state_q == ST_FETCH)    state_q <= ST_DECODE;
            else if (cls == CLS_LOAD)   state_q <= ST_WRITEBACK;
            else                        state_q <= ST_FETCH;
          end else if (wait_expired) begin
            wait_cnt <= '0;
            state_q  <= ST_HALT;
            halted   <= 1'b1;
            illegal  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DECODE: begin
          wait_cnt <= '0;
          if (cls == CLS_SYSTEM) begin
            state_q <= ST_HALT;
            halted  <= 1'b1;
          end else if (cls == CLS_ILLEGAL) begin
            state_q <= ST_HALT;
            halted  <= 1'b1;
            illegal <= 1'b1;
          end else begin
            state_q <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          wait_cnt <= '0;
          if (cls == CLS_BRANCH)                          state_q <= ST_FETCH;
          else if (cls == CLS_LOAD || cls == CLS_STORE)   state_q <= ST_MEM;
          else                                            state_q <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          wait_cnt <= '0;
          state_q  <= ST_FETCH;
        end
        ST_HALT: begin
          wait_cnt <= '0;
          halted   <= 1'b1;
        end
        default: begin
          wait_cnt <= '0;
          state_q  <= ST_HALT;
          halted   <= 1'b1;
          illegal  <= 1'b1;
        end
      endcase
    end
  end

  // Datapath controls decoded from state and IR; everything forced low while in reset
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    rf_we        = 1'b0;
    pc_we        = 1'b0;
    wb_sel       = WB_ALU;
    alu_src_a    = SRC_A_RS1;
    alu_src_b    = SRC_B_RS2;
    alu_op       = ALU_ADD;
    pc_sel       = PC_PLUS4;
    if (rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        ST_EXECUTE: begin
          alu_op = dec_alu_op;
          case (cls)
            CLS_LUI:            begin alu_src_a = SRC_A_ZERO; alu_src_b = SRC_B_IMM; end
            CLS_AUIPC, CLS_JAL: begin alu_src_a = SRC_A_PC;   alu_src_b = SRC_B_IMM; end
            CLS_OP, CLS_BRANCH: begin alu_src_a = SRC_A_RS1;  alu_src_b = SRC_B_RS2; end
            default:            begin alu_src_a = SRC_A_RS1;  alu_src_b = SRC_B_IMM; end
          endcase
          if (cls == CLS_BRANCH) begin
            pc_we  = 1'b1;
            pc_sel = branch_taken ? PC_REL : PC_PLUS4;
          end
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (cls == CLS_STORE);
          pc_we        = (cls == CLS_STORE) && mem_ready;
        end
        ST_WRITEBACK: begin
          rf_we = !rd_is_zero;
          pc_we = 1'b1;
          case (cls)
            CLS_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_REL;  end
            CLS_JALR: begin wb_sel = WB_PC4; pc_sel = PC_JALR; end
            CLS_LOAD: begin wb_sel = WB_MEM; pc_sel = PC_PLUS4; end
            default:  begin wb_sel = WB_ALU; pc_sel = PC_PLUS4; end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed cases plus a random
// instruction stream checked against per-instruction expectations derived
// from the class rules (latency, pulse counts, selects).
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, rf_we, pc_we;
  logic [1:0]  wb_sel, alu_src_a, pc_sel;
  logic        alu_src_b;
  logic [3:0]  alu_op;
  logic        halted, illegal;
  logic [2:0]  state;

  cpu_control_fsm #(.MEM_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .instr(instr), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we),
    .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_sel(pc_sel), .halted(halted), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BR = 4,
                 K_LD = 5, K_ST = 6, K_OPI = 7, K_OP = 8;
  logic [6:0] opc_tab [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  function automatic int kind_of(input logic [31:0] w);
    for (int i = 0; i < 9; i++) if (w[6:0] == opc_tab[i]) return i;
    return -1;
  endfunction

  // Execute one instruction starting in FETCH; nxt is loaded into IR on ir_we.
  // fd/md: cycles of mem_ready low before acceptance in fetch/data access.
  task automatic run_instr(input logic [31:0] nxt, input logic tk, input int fd, input int md);
    int k, cyc, fw, mw, n_ir, n_rf, n_pc, n_mw, n_mr, n_ex;
    int exp_cyc, exp_rf, exp_pcsel, exp_wb, exp_a, exp_b, exp_op;
    logic [2:0] st, f3;
    logic rdy, latch, done, writes, is_mem;
    logic [1:0] g_pcsel, g_wb, g_a;
    logic g_b;
    logic [3:0] g_op;
    k = kind_of(nxt);
    f3 = nxt[14:12];
    writes = (k != K_BR) && (k != K_ST);
    is_mem = (k == K_LD) || (k == K_ST);
    exp_cyc = ((k == K_BR) ? 3 : (k == K_LD) ? 5 : 4) + fd + (is_mem ? md : 0);
    exp_rf = (writes && nxt[11:7] != 5'd0) ? 1 : 0;
    exp_pcsel = (k == K_BR) ? (tk ? 1 : 0) : (k == K_JAL) ? 1 : (k == K_JALR) ? 2 : 0;
    exp_wb = (k == K_JAL || k == K_JALR) ? 2 : (k == K_LD) ? 1 : 0;
    exp_a = (k == K_LUI) ? 2 : (k == K_AUIPC || k == K_JAL) ? 1 : 0;
    exp_b = (k == K_OP || k == K_BR) ? 0 : 1;
    exp_op = (k == K_OP) ? {nxt[30], f3} :
             (k == K_OPI) ? ((f3 == 3'b101) ? {nxt[30], f3} : {1'b0, f3}) :
             (k == K_BR) ? 8 : 0;
    {cyc, fw, mw, n_ir, n_rf, n_pc, n_mw, n_mr, n_ex} = '0;
    g_pcsel = '1; g_wb = '1; g_a = '1; g_b = 1'bx; g_op = '1;
    done = 1'b0;
    branch_taken = tk;
    while (!done && cyc < 40) begin
      @(negedge clk);
      st = state;
      if (mem_req) rdy = (st == 3'd0) ? (fw == fd) : (mw == md);
      else rdy = 1'($urandom_range(0, 1));
      mem_ready = rdy;
      #1;
      cyc++;
      if (mem_req && !rdy) begin
        if (st == 3'd0) fw++; else mw++;
      end
      latch = ir_we;
      n_ir += int'(ir_we); n_rf += int'(rf_we); n_mw += int'(mem_we); n_mr += int'(mem_req);
      if (state == 3'd2) begin
        n_ex++; g_a = alu_src_a; g_b = alu_src_b; g_op = alu_op;
      end
      if (pc_we) begin
        n_pc++; g_pcsel = pc_sel; g_wb = wb_sel; done = 1'b1;
      end
      if (halted) done = 1'b1;
      @(posedge clk);
      if (latch) begin
        #1 instr = nxt;
      end
    end
    #1;
    chk("instr_done", done, 1);
    chk("cycles", cyc, exp_cyc);
    chk("ir_we_count", n_ir, 1);
    chk("rf_we_count", n_rf, exp_rf);
    chk("pc_we_count", n_pc, 1);
    chk("pc_sel", g_pcsel, exp_pcsel);
    if (writes) chk("wb_sel", g_wb, exp_wb);
    chk("mem_we_count", n_mw, (k == K_ST) ? md + 1 : 0);
    chk("mem_req_count", n_mr, fd + 1 + (is_mem ? md + 1 : 0));
    chk("execute_count", n_ex, 1);
    chk("alu_src_a", g_a, exp_a);
    chk("alu_src_b", g_b, exp_b);
    chk("alu_op", g_op, exp_op);
    chk("back_to_fetch", state, 0);
  endtask

  task automatic reset_pulse_check();
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_enables", {mem_req, ir_we, rf_we, pc_we, mem_we}, 0);
    chk("rst_selects", {mem_addr_sel, wb_sel, alu_src_a, alu_src_b, alu_op, pc_sel}, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("first_mem_req", mem_req, 1);
  endtask

  task automatic run_halt(input logic [31:0] nxt, input logic exp_ill);
    logic acc;
    @(negedge clk);
    mem_ready = 1'b1;
    #1 chk("halt_fetch_ir_we", ir_we, 1);
    @(posedge clk);
    #1 instr = nxt;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("halt_state", state, 7);
    chk("halt_halted", halted, 1);
    chk("halt_illegal", illegal, exp_ill);
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1 acc |= mem_req | ir_we | rf_we | pc_we | mem_we;
    end
    chk("halt_quiet", acc, 0);
    chk("halt_held", state, 7);
    chk("halt_illegal_sticky", illegal, exp_ill);
    reset_pulse_check();
  endtask

  initial begin
    int n;
    logic [31:0] r, ins;
    int k;
    rst = 1'b0;
    instr = 32'h0;
    branch_taken = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    reset_pulse_check();

    run_instr(32'h00500093, 1'b0, 0, 0);   // ADDI x1,x0,5
    run_instr(32'h00208463, 1'b1, 0, 0);   // BEQ taken
    run_instr(32'h00208463, 1'b0, 1, 0);   // BEQ not taken
    run_instr(32'h0000A103, 1'b0, 0, 3);   // LW, data ready after 3 wait cycles
    run_instr(32'h00208033, 1'b0, 0, 0);   // ADD x0,x1,x2
    run_instr(32'h0020A023, 1'b0, 2, 2);   // SW
    run_instr(32'h008000EF, 1'b0, 0, 0);   // JAL
    run_instr(32'h40515093, 1'b0, 0, 0);   // SRAI

    for (int i = 0; i < 40; i++) begin
      r = $urandom();
      k = $urandom_range(0, 8);
      ins = {r[31:7], opc_tab[k]};
      run_instr(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    run_halt(32'h0000007F, 1'b1);
    run_halt(32'h00000073, 1'b0);

    // Fetch timeout: ready never arrives
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (state == 3'd7) break;
      n++;
      @(negedge clk);
    end
    chk("timeout_cycles", n, 255);
    chk("timeout_halted", halted, 1);
    chk("timeout_illegal", illegal, 1);

    // Reset in the middle of a store's data access
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 mem_ready = 1'b1;
    @(posedge clk);
    #1 instr = 32'h0020A023;
    mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("sw_in_mem", state, 3);
    chk("sw_mem_we", mem_we, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_enables", {pc_we, rf_we, mem_req, mem_we}, 0);
    chk("abort_state", state, 0);
    @(posedge clk);
    #1 chk("abort_hold_pc_we", pc_we, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_refetch_state", state, 0);
    chk("abort_refetch_req", mem_req, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
